// File: rtl/knn_sort_ctrl_if.sv
// Memory-read and sorter-control bundle between knn_sort_ctrl (master) and the
// training memory / insertion sorter datapath (slave).
`timescale 1ns/1ps
interface knn_sort_ctrl_if #(
    parameter int W      = 32,
    parameter int ADDR_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [W/2-1:0]    mem_x;
    logic [W/2-1:0]    mem_y;
    logic              srt_rst;
    logic              srt_ready;
    logic              srt_done;
    logic [1:0]        srt_sel;
    logic [W/2-1:0]    srt_x1;
    logic [W/2-1:0]    srt_y1;
    logic [W/2-1:0]    srt_x2;
    logic [W/2-1:0]    srt_y2;
    logic [W/4-1:0]    srt_idx;

    modport master (
        output mem_en, mem_addr, srt_rst, srt_ready, srt_done, srt_sel,
        output srt_x1, srt_y1, srt_x2, srt_y2,
        input  mem_x, mem_y, srt_idx
    );

    modport slave (
        input  mem_en, mem_addr, srt_rst, srt_ready, srt_done, srt_sel,
        input  srt_x1, srt_y1, srt_x2, srt_y2,
        output mem_x, mem_y, srt_idx
    );
endinterface

// File: rtl/knn_sort_ctrl.sv
// Sequencer for one kNN query on the 4-entry insertion sorter: clear, stream
// n_points from memory, read back 4 nearest indices. Optional KNN_CYCLE_CNT_EN.
`timescale 1ns/1ps
module knn_sort_ctrl #(
    parameter int W      = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_points,
    input  logic [W/2-1:0]    test_x,
    input  logic [W/2-1:0]    test_y,
    output logic              busy,
    output logic              done,
    output logic [W-1:0]      nn_idx,
`ifdef KNN_CYCLE_CNT_EN
    output logic [W-1:0]      cycles,
`endif
    knn_sort_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_READ, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] n_q;
    logic [W/2-1:0]    tx_q, ty_q;
    logic              ready_q;
    logic              mem_en_c, srt_rst_c, srt_done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n_q     <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            ready_q <= 1'b0;
            nn_idx  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= mem_en_c;
            // cnt doubles as fetch address and readout select; restarts per state
            if (state_next != state)
                cnt <= '0;
            else if (state == S_FETCH || state == S_READ)
                cnt <= cnt + 1'b1;
            if (state == S_IDLE && start) begin
                n_q  <= n_points;
                tx_q <= test_x;
                ty_q <= test_y;
            end
            if (state == S_CLEAR)
                nn_idx <= '0;
            else if (state == S_READ)
                nn_idx[int'(cnt[1:0])*(W/4) +: W/4] <= bus.srt_idx;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        mem_en_c   = 1'b0;
        srt_rst_c  = 1'b0;
        srt_done_c = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: begin
                srt_rst_c  = 1'b1;
                state_next = (n_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                mem_en_c = 1'b1;
                if (cnt == n_q - 1'b1) state_next = S_DRAIN;
            end
            S_DRAIN: state_next = S_READ;
            S_READ: begin
                srt_done_c = 1'b1;
                if (cnt[1:0] == 2'd3) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_addr  = mem_en_c ? cnt : '0;
    assign bus.srt_rst   = srt_rst_c;
    assign bus.srt_ready = ready_q;
    assign bus.srt_done  = srt_done_c;
    assign bus.srt_sel   = srt_done_c ? cnt[1:0] : 2'd0;
    assign bus.srt_x1    = bus.mem_x;
    assign bus.srt_y1    = bus.mem_y;
    assign bus.srt_x2    = tx_q;
    assign bus.srt_y2    = ty_q;

`ifdef KNN_CYCLE_CNT_EN
    // Zeroed on the edge that enters CLEAR, so the count includes every busy cycle
    always_ff @(posedge clk) begin
        if (rst)
            cycles <= '0;
        else if (state == S_IDLE && start)
            cycles <= '0;
        else if (busy && cycles != '1)
            cycles <= cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Directed bench for knn_sort_ctrl with behavioural training memory and
// squared-distance 4-entry insertion sorter attached through the interface.
`timescale 1ns/1ps
module tb_knn_sort_ctrl;
    localparam int W      = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] n_points;
    logic [W/2-1:0]    test_x, test_y;
    logic              busy, done;
    logic [W-1:0]      nn_idx;
`ifdef KNN_CYCLE_CNT_EN
    logic [W-1:0]      cycles;
`endif

    knn_sort_ctrl_if #(.W(W), .ADDR_W(ADDR_W)) bus ();

    knn_sort_ctrl #(.W(W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_points (n_points),
        .test_x   (test_x),
        .test_y   (test_y),
        .busy     (busy),
        .done     (done),
        .nn_idx   (nn_idx),
`ifdef KNN_CYCLE_CNT_EN
        .cycles   (cycles),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // training memory, 1-cycle read latency
    logic [15:0] mx [256];
    logic [15:0] my [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_x <= mx[bus.mem_addr];
            bus.mem_y <= my[bus.mem_addr];
        end
    end

    // insertion sorter: strictly-less compare, index = insert count
    logic [63:0] s_d [4];
    logic [7:0]  s_i [4];
    logic [7:0]  s_cnt;
    logic [63:0] ins_d, dx, dy;
    int          ins_p;
    always @(posedge clk) begin
        if (rst || bus.srt_rst) begin
            for (int k = 0; k < 4; k++) begin
                s_d[k] <= '1;
                s_i[k] <= '0;
            end
            s_cnt <= '0;
        end else if (bus.srt_ready && !bus.srt_done) begin
            dx = (bus.srt_x1 >= bus.srt_x2) ? 64'(bus.srt_x1 - bus.srt_x2) : 64'(bus.srt_x2 - bus.srt_x1);
            dy = (bus.srt_y1 >= bus.srt_y2) ? 64'(bus.srt_y1 - bus.srt_y2) : 64'(bus.srt_y2 - bus.srt_y1);
            ins_d = dx * dx + dy * dy;
            ins_p = 4;
            for (int k = 3; k >= 0; k--)
                if (ins_d < s_d[k]) ins_p = k;
            for (int k = 3; k >= 1; k--)
                if (k > ins_p) begin
                    s_d[k] <= s_d[k-1];
                    s_i[k] <= s_i[k-1];
                end
            if (ins_p < 4) begin
                s_d[ins_p] <= ins_d;
                s_i[ins_p] <= s_cnt;
            end
            s_cnt <= s_cnt + 8'd1;
        end
    end
    assign bus.srt_idx = s_i[bus.srt_sel];

    typedef struct packed {
        logic [7:0]        n;
        logic [15:0]       tx;
        logic [15:0]       ty;
        logic [9:0][15:0]  px;
        logic [9:0][15:0]  py;
        logic              rep;
        logic [31:0]       exp_idx;
        logic [15:0]       exp_done;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setpt(input int v, input int i, input int x, input int y);
        vecs[v].px[i] = 16'(x);
        vecs[v].py[i] = 16'(y);
    endtask

    task automatic run_query(input vec_t v);
        int busy_bad, rdy, addr_bad, expaddr, done_cyc, extra_done;
        logic [31:0] nn_seen;
        busy_bad = 0; rdy = 0; addr_bad = 0; expaddr = 0; done_cyc = -1; extra_done = 0;
        nn_seen = '0;
        for (int i = 0; i < 10; i++) begin
            mx[i] = v.px[i];
            my[i] = v.py[i];
        end
        @(negedge clk);
        start = 1'b1; n_points = v.n; test_x = v.tx; test_y = v.ty;
        @(negedge clk);
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            start = (v.rep && c == 5);
            if (!busy) busy_bad++;
            if (bus.srt_ready) rdy++;
            if (bus.mem_en) begin
                if (int'(bus.mem_addr) != expaddr) addr_bad++;
                expaddr++;
            end
            if (done) begin
                done_cyc = c;
                nn_seen  = nn_idx;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        check("nn_idx", 64'(nn_seen), 64'(v.exp_idx));
        check("ready_pulses", 64'(rdy), 64'(v.n));
        check("mem_addr_seq", 64'(addr_bad), 64'd0);
        check("fetch_beats", 64'(expaddr), 64'(v.n));
        check("busy_during", 64'(busy_bad), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        for (int c = 0; c < 6; c++) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        check("single_done", 64'(extra_done), 64'd0);
        check("nn_idx_hold", 64'(nn_idx), 64'(v.exp_idx));
`ifdef KNN_CYCLE_CNT_EN
        check("cycles_hold", 64'(cycles), 64'(v.exp_done));
`endif
    endtask

    initial begin
        int waited, dpulses;
        foreach (vecs[i]) vecs[i] = '0;
        // 0: mixed distances, test at origin
        vecs[0].n = 6; vecs[0].exp_idx = 32'h02030501; vecs[0].exp_done = 13;
        setpt(0,0,5,5); setpt(0,1,1,0); setpt(0,2,3,3);
        setpt(0,3,0,2); setpt(0,4,9,9); setpt(0,5,1,1);
        // 1: empty query
        vecs[1].n = 0; vecs[1].exp_idx = 32'h0; vecs[1].exp_done = 2;
        // 2: two points, upper slots stay 0
        vecs[2].n = 2; vecs[2].exp_idx = 32'h00000001; vecs[2].exp_done = 9;
        setpt(2,0,2,0); setpt(2,1,1,0);
        // 3: ten points, start re-pulsed during fetch
        vecs[3].n = 10; vecs[3].rep = 1'b1; vecs[3].exp_idx = 32'h06070809; vecs[3].exp_done = 17;
        for (int i = 0; i < 10; i++) setpt(3, i, 10 - i, 0);
        // 4: distance ties keep earlier index lower
        vecs[4].n = 4; vecs[4].exp_idx = 32'h02030100; vecs[4].exp_done = 11;
        setpt(4,0,1,0); setpt(4,1,0,1); setpt(4,2,2,0); setpt(4,3,1,0);
        // 5: non-origin test point
        vecs[5].n = 3; vecs[5].tx = 16'd100; vecs[5].ty = 16'd50; vecs[5].exp_idx = 32'h00000201; vecs[5].exp_done = 10;
        setpt(5,0,103,50); setpt(5,1,100,50); setpt(5,2,99,51);

        rst = 1'b1; start = 1'b0; n_points = '0; test_x = '0; test_y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_nn_idx", 64'(nn_idx), 64'd0);
        check("rst_mem_en", 64'(bus.mem_en), 64'd0);
        check("rst_srt_ctl", 64'({bus.srt_rst, bus.srt_ready, bus.srt_done, bus.srt_sel}), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_test_pt", 64'({bus.srt_x2, bus.srt_y2}), 64'd0);
`ifdef KNN_CYCLE_CNT_EN
        check("rst_cycles", 64'(cycles), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NV; v++) run_query(vecs[v]);

        // start and rst together: rst wins
        start = 1'b1; rst = 1'b1; n_points = 8'd3;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("start_with_rst", 64'(busy), 64'd0);

        // reset during READ aborts with no done pulse
        for (int i = 0; i < 10; i++) begin
            mx[i] = vecs[0].px[i];
            my[i] = vecs[0].py[i];
        end
        start = 1'b1; n_points = vecs[0].n; test_x = '0; test_y = '0;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!bus.srt_done && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("reach_read", 64'(bus.srt_done), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_nn_idx", 64'(nn_idx), 64'd0);
        check("abort_done", 64'(done), 64'd0);
`ifdef KNN_CYCLE_CNT_EN
        check("abort_cycles", 64'(cycles), 64'd0);
`endif
        dpulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) dpulses++;
            @(negedge clk);
        end
        check("abort_quiet", 64'(dpulses), 64'd0);
        run_query(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
